// File: rtl/pcie_rc_pkg.sv
// ============================================================================
//  Module  : pcie_rc_pkg
//  Purpose : Shared constants for the RC completion realigner: descriptor
//            field offsets, FSM state encodings and the DW keep-mask helper.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pcie_rc_pkg;

    // Number of descriptor dwords at the head of every SOP beat
    localparam int DESC_DW = 3;

    // Descriptor field offsets inside the SOP beat
    localparam int DWC_LSB = 32;
    localparam int DWC_MSB = 42;
    localparam int ERR_LSB = 12;
    localparam int ERR_MSB = 15;

    // Widest supported bus is 512 bits = 16 dwords
    localparam int MAX_KW = 16;

    // FSM state encodings
    localparam int         STATE_W   = 2;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_DROP   = 2'd3;

    // Contiguous DW-enable mask: min(count, kw) ones starting at bit 0
    function automatic logic [MAX_KW-1:0] dw_keep_mask(input logic [10:0] count,
                                                      input int         kw);
        logic [MAX_KW-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_KW; i++) begin
            if ((i < kw) && (11'(i) < count)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rc_realigner_if.sv
// ============================================================================
//  Module  : rc_realigner_if
//  Purpose : Bundles the RC AXI-Stream input and the aligned user output of
//            the realigner.
//  Modports: slave  - the realigner (consumes RC stream, drives user stream)
//            master - the environment (drives RC stream, consumes user stream)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface rc_realigner_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 75
);
    localparam int KW = DATA_WIDTH / 32;

    logic [DATA_WIDTH-1:0]  m_axis_rc_tdata;
    logic                   m_axis_rc_tvalid;
    logic [TUSER_WIDTH-1:0] m_axis_rc_tuser;
    logic [KW-1:0]          m_axis_rc_tkeep;
    logic                   m_axis_rc_tlast;
    logic                   m_axis_rc_tready;

    logic                   rc_valid;
    logic                   rc_ready;
    logic [DATA_WIDTH-1:0]  rc_payload;
    logic [KW-1:0]          rc_payload_dw_keep;
    logic                   rc_payload_last;
    logic                   rc_desc_valid;
    logic [95:0]            rc_descriptor;
    logic                   rc_err;

    modport slave (
        input  m_axis_rc_tdata, m_axis_rc_tvalid, m_axis_rc_tuser,
               m_axis_rc_tkeep, m_axis_rc_tlast, rc_ready,
        output m_axis_rc_tready, rc_valid, rc_payload, rc_payload_dw_keep,
               rc_payload_last, rc_desc_valid, rc_descriptor, rc_err
    );

    modport master (
        output m_axis_rc_tdata, m_axis_rc_tvalid, m_axis_rc_tuser,
               m_axis_rc_tkeep, m_axis_rc_tlast, rc_ready,
        input  m_axis_rc_tready, rc_valid, rc_payload, rc_payload_dw_keep,
               rc_payload_last, rc_desc_valid, rc_descriptor, rc_err
    );

endinterface

`default_nettype wire

// File: rtl/rc_realign_out_reg.sv
// ============================================================================
//  Module  : rc_realign_out_reg
//  Purpose : Single valid/ready output register for the realigned word.
//            Accepts a new word whenever it is empty or being drained.
//  Ports   : clk, rst_n        - clock, async active-low reset
//            load, load_*      - word to capture when can_load is high
//            out_ready         - downstream ready
//            can_load          - register can take a word this cycle
//            out_*             - registered word presented downstream
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rc_realign_out_reg #(
    parameter int DATA_WIDTH = 256,
    parameter int KW         = DATA_WIDTH / 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_payload,
    input  logic [KW-1:0]         load_keep,
    input  logic                  load_last,
    input  logic                  load_desc,
    input  logic                  out_ready,
    output logic                  can_load,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_payload,
    output logic [KW-1:0]         out_keep,
    output logic                  out_last,
    output logic                  out_desc
);

    logic                  valid_q,   valid_d;
    logic [DATA_WIDTH-1:0] payload_q, payload_d;
    logic [KW-1:0]         keep_q,    keep_d;
    logic                  last_q,    last_d;
    logic                  desc_q,    desc_d;

    assign can_load = !valid_q || out_ready;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        keep_d    = keep_q;
        last_d    = last_q;
        desc_d    = desc_q;
        if (can_load) begin
            valid_d = load;
            // Sideband flags never linger on an empty register
            last_d  = load && load_last;
            desc_d  = load && load_desc;
            if (load) begin
                payload_d = load_payload;
                keep_d    = load_keep;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            desc_q    <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            keep_q    <= keep_d;
            last_q    <= last_d;
            desc_q    <= desc_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_payload = payload_q;
    assign out_keep    = keep_q;
    assign out_last    = last_q;
    assign out_desc    = desc_q;

endmodule

`default_nettype wire

// File: rtl/rc_realigner.sv
// ============================================================================
//  Module  : rc_realigner
//  Purpose : PCIe RC completion realigner. Strips the 3-DW descriptor from
//            each SOP beat and shifts payload so DW0 lands at bit 0 of every
//            output word. Last/keep come from the descriptor dword count,
//            with a flush beat for residue left in the holding register.
//  Ports   : clk, rst_n  - clock, async active-low reset
//            bus         - rc_realigner_if.slave (RC input + user output)
//  Config  : RC_REALIGN_DROP_POISON_EN - when defined, packets whose
//            descriptor error code is non-zero are dropped silently apart
//            from one rc_err pulse at their SOP.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rc_realigner
    import pcie_rc_pkg::*;
#(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 75,
    parameter int SOP_BIT     = 32
) (
    input logic          clk,
    input logic          rst_n,
    rc_realigner_if.slave bus
);

    localparam int         KW    = DATA_WIDTH / 32;
    localparam int         HW    = DATA_WIDTH - 32 * DESC_DW;
    localparam logic [10:0] P_DW  = 11'(KW - DESC_DW);
    localparam logic [10:0] KW_DW = 11'(KW);

    logic [STATE_W-1:0] state_q, state_d;
    logic [10:0]        rem_q,   rem_d;
    logic [HW-1:0]      hold_q,  hold_d;
    logic [95:0]        desc_q,  desc_d;
    logic               first_q, first_d;
    logic               err_q,   err_d;

    logic                  can_load, out_valid, accept, sop, in_last, poison;
    logic [10:0]           dwc, take, rem_left;
    logic                  load, load_last, load_desc;
    logic [DATA_WIDTH-1:0] load_payload;
    logic [10:0]           load_count;
    logic [MAX_KW-1:0]     keep_full;

    assign bus.m_axis_rc_tready = rst_n && can_load && (state_q != ST_FLUSH);
    assign accept   = bus.m_axis_rc_tvalid && bus.m_axis_rc_tready;
    assign sop      = bus.m_axis_rc_tuser[SOP_BIT];
    assign in_last  = bus.m_axis_rc_tlast;
    assign dwc      = bus.m_axis_rc_tdata[DWC_MSB:DWC_LSB];
    assign take     = (rem_q < KW_DW) ? rem_q : KW_DW;
    assign rem_left = rem_q - take;

`ifdef RC_REALIGN_DROP_POISON_EN
    assign poison = (bus.m_axis_rc_tdata[ERR_MSB:ERR_LSB] != 4'd0);
`else
    assign poison = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        hold_d       = hold_q;
        desc_d       = desc_q;
        first_d      = first_q;
        err_d        = 1'b0;
        load         = 1'b0;
        load_payload = '0;
        load_count   = '0;
        load_last    = 1'b0;
        load_desc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!sop) begin
                        err_d = 1'b1;
                    end else begin
                        desc_d = bus.m_axis_rc_tdata[95:0];
                        hold_d = bus.m_axis_rc_tdata[DATA_WIDTH-1:96];
                        if (poison) begin
                            err_d = 1'b1;
                            if (!in_last) state_d = ST_DROP;
                        end else if (dwc <= P_DW) begin
                            load         = 1'b1;
                            load_payload = {96'b0, bus.m_axis_rc_tdata[DATA_WIDTH-1:96]};
                            load_count   = dwc;
                            load_last    = 1'b1;
                            load_desc    = 1'b1;
                        end else if (in_last) begin
                            // Packet ends in its SOP beat but claims more data:
                            // deliver what arrived as a truncated last word
                            err_d   = 1'b1;
                            rem_d   = P_DW;
                            first_d = 1'b1;
                            state_d = ST_FLUSH;
                        end else begin
                            rem_d   = dwc;
                            first_d = 1'b1;
                            state_d = ST_STREAM;
                        end
                    end
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    load         = 1'b1;
                    load_payload = {bus.m_axis_rc_tdata[95:0], hold_q};
                    load_count   = take;
                    load_desc    = first_q;
                    first_d      = 1'b0;
                    hold_d       = bus.m_axis_rc_tdata[DATA_WIDTH-1:96];
                    rem_d        = rem_left;
                    if (rem_left == 11'd0) begin
                        load_last = 1'b1;
                        if (in_last) begin
                            state_d = ST_IDLE;
                        end else begin
                            // Count exhausted early: discard beats up to tlast
                            err_d   = 1'b1;
                            state_d = ST_DROP;
                        end
                    end else if (in_last) begin
                        state_d = ST_FLUSH;
                        if (rem_left > P_DW) begin
                            // Early tlast: flush only what the holding register has
                            err_d = 1'b1;
                            rem_d = P_DW;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (can_load) begin
                    load         = 1'b1;
                    load_payload = {96'b0, hold_q};
                    load_count   = rem_q;
                    load_last    = 1'b1;
                    load_desc    = first_q;
                    first_d      = 1'b0;
                    rem_d        = '0;
                    state_d      = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (accept && in_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            hold_q  <= '0;
            desc_q  <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            hold_q  <= hold_d;
            desc_q  <= desc_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    assign keep_full = dw_keep_mask(load_count, KW);

    logic                  o_valid, o_last, o_desc;
    logic [DATA_WIDTH-1:0] o_payload;
    logic [KW-1:0]         o_keep;

    rc_realign_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .KW         (KW)
    ) u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .load_payload (load_payload),
        .load_keep    (keep_full[KW-1:0]),
        .load_last    (load_last),
        .load_desc    (load_desc),
        .out_ready    (bus.rc_ready),
        .can_load     (can_load),
        .out_valid    (o_valid),
        .out_payload  (o_payload),
        .out_keep     (o_keep),
        .out_last     (o_last),
        .out_desc     (o_desc)
    );

    assign out_valid              = o_valid;
    assign bus.rc_valid           = out_valid;
    assign bus.rc_payload         = o_payload;
    assign bus.rc_payload_dw_keep = o_keep;
    assign bus.rc_payload_last    = o_last;
    assign bus.rc_desc_valid      = o_desc;
    assign bus.rc_descriptor      = desc_q;
    assign bus.rc_err             = err_q;

    // tkeep and the rest of tuser carry nothing this block needs
    logic unused_bits;
    assign unused_bits = ^{keep_full, bus.m_axis_rc_tkeep, bus.m_axis_rc_tuser};

endmodule

`default_nettype wire

// File: tb/tb_rc_realigner.sv
// ============================================================================
//  Module  : tb_rc_realigner
//  Purpose : Self-checking bench for rc_realigner at 256 and 512 bits.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rc_realigner;

    typedef struct {
        logic [511:0] pay;
        logic [15:0]  keep;
        logic         last;
        logic         desc;
        logic [95:0]  dsc;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rc_realigner_if #(.DATA_WIDTH(256), .TUSER_WIDTH(75))  i0 ();
    rc_realigner_if #(.DATA_WIDTH(512), .TUSER_WIDTH(161)) i1 ();

    rc_realigner #(.DATA_WIDTH(256), .TUSER_WIDTH(75), .SOP_BIT(32)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(i0));
    rc_realigner #(.DATA_WIDTH(512), .TUSER_WIDTH(161), .SOP_BIT(32)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(i1));

    int n_tests = 0;
    int n_fail  = 0;
    int nw0 = 0, nw1 = 0;
    int err_cnt0 = 0, err_cnt1 = 0;
    logic rand_ready = 1'b0;
    word_t exp_q0[$];
    word_t exp_q1[$];
    logic [511:0] pkt_beats[$];
    word_t em0, em1;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: payload stream = all beat dwords after the descriptor, cut
    // into KW-dword words; ceil(dwc/kw) words (at least one), zero beyond the
    // received data.
    task automatic model_packet(input int sel, input int kw, input int dwc, input logic [95:0] dsc);
        logic [31:0] s[$];
        logic [511:0] b;
        word_t w;
        int nwords, cnt, idx;
        for (int i = 0; i < pkt_beats.size(); i++) begin
            b = pkt_beats[i];
            for (int j = 0; j < kw; j++)
                if (i > 0 || j >= 3) s.push_back(b[j*32 +: 32]);
        end
        nwords = (dwc == 0) ? 1 : (dwc + kw - 1) / kw;
        for (int k = 0; k < nwords; k++) begin
            w.pay = '0;
            for (int j = 0; j < kw; j++) begin
                idx = k * kw + j;
                if (idx < s.size()) w.pay[j*32 +: 32] = s[idx];
            end
            cnt = dwc - k * kw;
            if (cnt > kw) cnt = kw;
            w.keep = '0;
            for (int j = 0; j < cnt; j++) w.keep[j] = 1'b1;
            w.last = (k == nwords - 1);
            w.desc = (k == 0);
            w.dsc  = dsc;
            if (sel == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
        end
    endtask

    task automatic send256(input logic [255:0] d, input logic sop, input logic last);
        int n = 0;
        logic ok = 1'b0;
        i0.m_axis_rc_tdata  = d;
        i0.m_axis_rc_tuser  = '0;
        i0.m_axis_rc_tuser[32] = sop;
        i0.m_axis_rc_tlast  = last;
        i0.m_axis_rc_tvalid = 1'b1;
        while (!ok && n < 500) begin
            @(negedge clk); ok = i0.m_axis_rc_tready;
            @(posedge clk); #1; n++;
        end
        i0.m_axis_rc_tvalid = 1'b0;
        if (!ok) check_val("tready_timeout0", 0, 1);
    endtask

    task automatic send512(input logic [511:0] d, input logic sop, input logic last);
        int n = 0;
        logic ok = 1'b0;
        i1.m_axis_rc_tdata  = d;
        i1.m_axis_rc_tuser  = '0;
        i1.m_axis_rc_tuser[32] = sop;
        i1.m_axis_rc_tlast  = last;
        i1.m_axis_rc_tvalid = 1'b1;
        while (!ok && n < 500) begin
            @(negedge clk); ok = i1.m_axis_rc_tready;
            @(posedge clk); #1; n++;
        end
        i1.m_axis_rc_tvalid = 1'b0;
        if (!ok) check_val("tready_timeout1", 0, 1);
    endtask

    task automatic send_pkt(input int sel, input int dwc, input int nb_force, input logic gaps);
        int kw = (sel != 0) ? 16 : 8;
        int nb;
        logic [511:0] b;
        nb = (nb_force > 0) ? nb_force : (dwc + 3 + kw - 1) / kw;
        pkt_beats.delete();
        for (int i = 0; i < nb; i++) begin
            for (int j = 0; j < 16; j++) b[j*32 +: 32] = $urandom;
            if (i == 0) b[42:32] = dwc[10:0];
            pkt_beats.push_back(b);
        end
        b = pkt_beats[0];
        model_packet(sel, kw, dwc, b[95:0]);
        for (int i = 0; i < nb; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            b = pkt_beats[i];
            if (sel == 0) send256(b[255:0], i == 0, i == nb - 1);
            else          send512(b, i == 0, i == nb - 1);
        end
    endtask

    // Output-side monitors against the reference queues
    always @(negedge clk) begin
        if (rst_n && i0.rc_err) err_cnt0++;
        if (rst_n && i0.rc_valid && i0.rc_ready) begin
            nw0++;
            if (exp_q0.size() == 0) check_val("unexpected_word0", 1, 0);
            else begin
                em0 = exp_q0.pop_front();
                check_val("payload0", i0.rc_payload, em0.pay);
                check_val("keep0", i0.rc_payload_dw_keep, em0.keep);
                check_val("last0", i0.rc_payload_last, em0.last);
                check_val("descv0", i0.rc_desc_valid, em0.desc);
                if (em0.desc) check_val("descriptor0", i0.rc_descriptor, em0.dsc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && i1.rc_err) err_cnt1++;
        if (rst_n && i1.rc_valid && i1.rc_ready) begin
            nw1++;
            if (exp_q1.size() == 0) check_val("unexpected_word1", 1, 0);
            else begin
                em1 = exp_q1.pop_front();
                check_val("payload1", i1.rc_payload, em1.pay);
                check_val("keep1", i1.rc_payload_dw_keep, em1.keep);
                check_val("last1", i1.rc_payload_last, em1.last);
                check_val("descv1", i1.rc_desc_valid, em1.desc);
                if (em1.desc) check_val("descriptor1", i1.rc_descriptor, em1.dsc);
            end
        end
    end

    // Downstream ready: 50% random when enabled, otherwise always ready
    initial begin
        i0.rc_ready = 1'b1;
        i1.rc_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            i0.rc_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, e0, nb;
        logic [511:0] b;
        rst_n = 1'b0;
        i0.m_axis_rc_tdata = '0; i0.m_axis_rc_tvalid = 1'b0; i0.m_axis_rc_tuser = '0;
        i0.m_axis_rc_tkeep = '0; i0.m_axis_rc_tlast  = 1'b0;
        i1.m_axis_rc_tdata = '0; i1.m_axis_rc_tvalid = 1'b0; i1.m_axis_rc_tuser = '0;
        i1.m_axis_rc_tkeep = '0; i1.m_axis_rc_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_tready0", i0.m_axis_rc_tready, 0);
        check_val("rst_tready1", i1.m_axis_rc_tready, 0);
        check_val("rst_valid0", i0.rc_valid, 0);
        check_val("rst_keep0", i0.rc_payload_dw_keep, 0);
        check_val("rst_payload0", i0.rc_payload, 0);
        check_val("rst_descriptor0", i0.rc_descriptor, 0);
        check_val("rst_err0", i0.rc_err, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single SOP+tlast beat, DWC=4
        send_pkt(0, 4, 0, 0);
        @(negedge clk);
        check_val("single_valid", i0.rc_valid, 1);
        check_val("single_keep", i0.rc_payload_dw_keep, 8'h0F);
        check_val("single_last", i0.rc_payload_last, 1);
        check_val("single_descv", i0.rc_desc_valid, 1);
        @(posedge clk); #1;

        // DWC=16 in three beats: two full words, no flush
        send_pkt(0, 16, 0, 0);
        @(negedge clk);
        check_val("dwc16_keep", i0.rc_payload_dw_keep, 8'hFF);
        check_val("dwc16_last", i0.rc_payload_last, 1);
        check_val("dwc16_descv", i0.rc_desc_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("dwc16_noflush", i0.rc_valid, 0);
        @(posedge clk); #1;

        // DWC=10 in two beats: full word then a 2-DW flush word
        send_pkt(0, 10, 0, 0);
        @(negedge clk);
        check_val("dwc10_keep", i0.rc_payload_dw_keep, 8'hFF);
        check_val("dwc10_tready_flush", i0.m_axis_rc_tready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("dwc10_flush_keep", i0.rc_payload_dw_keep, 8'h03);
        check_val("dwc10_flush_last", i0.rc_payload_last, 1);
        check_val("dwc10_tready_back", i0.m_axis_rc_tready, 1);
        @(posedge clk); #1;

        // 512-bit DWC=20: full word then 4-DW flush starting at beat-2 DW3
        send_pkt(1, 20, 0, 0);
        @(negedge clk);
        check_val("w512_keep", i1.rc_payload_dw_keep, 16'hFFFF);
        @(posedge clk); #1;
        @(negedge clk);
        b = pkt_beats[1];
        check_val("w512_flush_keep", i1.rc_payload_dw_keep, 16'h000F);
        check_val("w512_dw16", i1.rc_payload[31:0], b[127:96]);
        @(posedge clk); #1;

        // DWC=8 but tlast only on beat 3: error pulse, beat 3 dropped
        e0 = err_cnt0;
        send_pkt(0, 8, 3, 0);
        repeat (3) @(posedge clk);
        #1;
        check_val("mismatch_err", err_cnt0 - e0, 1);
        send_pkt(0, 12, 0, 0);

        // Back-to-back random packets with random downstream ready
        rand_ready = 1'b1;
        for (int p = 0; p < 20; p++) send_pkt(0, $urandom_range(0, 40), 0, 1);
        n = 0;
        while (exp_q0.size() != 0 && n < 2000) begin @(posedge clk); n++; end
        rand_ready = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a packet: nothing comes out afterwards
        nb = nw0;
        for (int j = 0; j < 16; j++) b[j*32 +: 32] = $urandom;
        b[42:32] = 11'd30;
        send256(b[255:0], 1'b1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_tready", i0.m_axis_rc_tready, 0);
        check_val("midrst_valid", i0.rc_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_val("midrst_no_output", nw0 - nb, 0);
        send_pkt(0, 7, 0, 0);

        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 2000) begin
            @(posedge clk); n++;
        end
        repeat (2) @(posedge clk);
        check_val("drain_q0", exp_q0.size(), 0);
        check_val("drain_q1", exp_q1.size(), 0);
        check_val("err_total0", err_cnt0, 1);
        check_val("err_total1", err_cnt1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rc_realigner.md
# rc_realigner

Parametrised completion-channel realigner between the PCIe RC AXI-Stream master and user DMA logic. Strips the 3-DW descriptor from each SOP beat and shifts payload so user logic sees DW0 at bit 0 of every output word. Tracks the remaining dword count so `last` and `keep` do not depend on `tlast`. Adds output backpressure, a flush beat for tail residue, 256/512-bit width support and a per-packet descriptor strobe.

## Interface
- `DATA_WIDTH`, 256: bus width, 256 or 512; `KW = DATA_WIDTH/32`.
- `TUSER_WIDTH`, 75: RC tuser width (161 for 512).
- `SOP_BIT`, 32: tuser bit flagging start of packet.
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `m_axis_rc_tdata` in DATA_WIDTH: RC data.
- `m_axis_rc_tvalid` in 1: RC valid.
- `m_axis_rc_tuser` in TUSER_WIDTH: RC sideband; only `SOP_BIT` is used.
- `m_axis_rc_tkeep` in KW: ignored, kept for the port list.
- `m_axis_rc_tlast` in 1: RC end of packet.
- `m_axis_rc_tready` out 1: RC ready.
- `rc_valid` out 1: output word valid.
- `rc_ready` in 1: user accepts the output word.
- `rc_payload` out DATA_WIDTH: aligned payload; DW0 sits at bits [31:0].
- `rc_payload_dw_keep` out KW: DW-enable mask, always contiguous from bit 0.
- `rc_payload_last` out 1: last word of the packet.
- `rc_desc_valid` out 1: asserted with the first output word of each packet.
- `rc_descriptor` out 96: descriptor of the current packet.
- `rc_err` out 1: one-cycle pulse on a tlast/count mismatch.

## Operation
- **Constants**
  - `P = KW-3`: payload DWs carried in the SOP beat (5 at 256 bits, 13 at 512 bits).
  - `DWC = tdata[42:32]`: dword count, 11-bit unsigned.
  - `rem`: remaining-DW counter, 11 bits.
  - `hold`: (KW-3)-DW holding register.
- **States:** `IDLE`, `STREAM`, `FLUSH`.
- **Input accept:** an input beat is accepted when `m_axis_rc_tvalid && m_axis_rc_tready`.
- **IDLE**
  - Acts only on a SOP beat; a non-SOP beat is consumed and dropped, and `rc_err` pulses.
  - Latches the descriptor (`tdata[95:0]`) and stores `hold = tdata[W-1:96]`.
  - If `DWC <= P`: emit `{0, tdata[W-1:96]}` with keep = DWC ones (DWC=0 gives keep 0), last=1, desc_valid=1. Stay in IDLE.
  - Otherwise: `rem = DWC`, go to STREAM. Nothing is emitted.
- **STREAM, per accepted beat**
  - Emit `{tdata[95:0], hold}` with keep = `min(rem, KW)` ones.
  - `desc_valid = 1` on the first emitted word of the packet.
  - Update `rem -= min(rem, KW)` and `hold = tdata[W-1:96]`.
  - Still in STREAM (`rem > 0`, no tlast): last=0, stay in STREAM.
  - `rem` reaches 0 on this word: last=1, go to IDLE.
  - `rem > 0` and tlast: go to FLUSH.
- **FLUSH**
  - `m_axis_rc_tready = 0`.
  - Emit `{0, hold}` with keep = `rem` ones (`rem <= P` by construction), last=1.
  - Return to IDLE.
- **Mismatch**
  - `rem` reaches 0 without tlast: the remaining input beats up to tlast are dropped, `rc_err` pulses once, then IDLE.
  - tlast arrives while `rem > P` after the update: `rc_err` pulses, a truncated last word is emitted, then IDLE.

## Timing
- Single registered output stage; the output word updates when `!rc_valid || rc_ready`.
- `m_axis_rc_tready = (!rc_valid || rc_ready) && state != FLUSH`. This is combinational from `rc_ready`; no skid buffer.
- Latency:
  - Single-beat packet: output 1 cycle after the input beat.
  - Multi-beat packet: first output 1 cycle after the second input beat.
  - FLUSH word: 1 cycle after the tlast word is accepted.
- Output data is held stable while `rc_valid && !rc_ready`.
- `rc_descriptor` is held until the next SOP is accepted.
- Reset values: all outputs 0, `m_axis_rc_tready` 0 during reset; state IDLE, `rem` 0, `hold` 0.
- Reset mid-packet: the partial packet is discarded; there is no output after reset release until the next SOP.
- Back-to-back: a SOP may be accepted in the cycle after tlast, except while in FLUSH.

## Configuration
- `RC_REALIGN_DROP_POISON_EN`
  - Defined: a packet whose descriptor error code `tdata[15:12] != 0` is consumed at full rate with no output words; `rc_err` pulses once at its SOP.
  - Undefined: error code is ignored and the packet is forwarded normally.

## Structure
- Package `pcie_rc_pkg`:
  - descriptor field offsets (DWC [42:32], error code [15:12]);
  - `DESC_DW = 3`;
  - state enum;
  - function `dw_keep_mask(count, KW)`.
- One sub-module: `rc_realign_out_reg`, the valid/ready output register holding payload, keep, last and desc_valid.

## Test plan
- 256-bit, DWC=4, single SOP+tlast beat: one word, keep 0x0F, last=1, desc_valid=1, payload = input[223:96].
- 256-bit, DWC=16, 3 input beats:
  - word 1: keep 0xFF, desc_valid=1, last=0;
  - word 2: keep 0xFF, last=1;
  - no FLUSH.
- 256-bit, DWC=10, 2 input beats: main word keep 0xFF; FLUSH word keep 0x03, last=1; tready low for that one cycle.
- 512-bit, DWC=20, 2 beats: word 1 keep 0xFFFF, FLUSH keep 0x000F with DW16 = input beat-2 DW3.
- Random `rc_ready` (50%) on 20 back-to-back packets: payload stream matches the reference model and no word is duplicated or dropped.
- DWC=8 but tlast on beat 3: `rc_err` pulses, beat 3 is dropped, next SOP is processed normally.
